t2mi_ts_null_stuffer: RTL and testbench

- Sits directly downstream of the T2-MI-over-TS encapsulator.
- Takes its bursty 188-byte TS packet stream (DATA/ENA/PSYNC) and buffers whole packets in a packet FIFO.
- Replays them at a constant byte rate set by an external slot tick, inserting null packets (PID 0x1FFF) whenever no complete packet is buffered, so the modulator interface sees a continuous CBR transport stream.

---
 rtl/t2mi_ts_null_stuffer_if.sv | 25 ++
 rtl/t2mi_ts_null_stuffer.sv | 237 +++++++++++++++++++++++
 tb/tb_t2mi_ts_null_stuffer.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/t2mi_ts_null_stuffer_if.sv
// Byte-stream bundle between the T2-MI encapsulator, the CBR null stuffer and the modulator side.
interface t2mi_ts_null_stuffer_if #(
    parameter int unsigned LVL_W = 3
);
    logic [7:0]       DATA_IN;
    logic             ENA_IN;
    logic             PSYNC_IN;
    logic             SLOT_TICK;
    logic [7:0]       DATA_OUT;
    logic             DVALID_OUT;
    logic             PSYNC_OUT;
    logic [LVL_W-1:0] PKT_LEVEL;
    logic [7:0]       OVF_CNT;
    logic [7:0]       SYNC_ERR_CNT;

    modport slave (
        input  DATA_IN, ENA_IN, PSYNC_IN, SLOT_TICK,
        output DATA_OUT, DVALID_OUT, PSYNC_OUT, PKT_LEVEL, OVF_CNT, SYNC_ERR_CNT
    );

    modport master (
        output DATA_IN, ENA_IN, PSYNC_IN, SLOT_TICK,
        input  DATA_OUT, DVALID_OUT, PSYNC_OUT, PKT_LEVEL, OVF_CNT, SYNC_ERR_CNT
    );
endinterface

// File: rtl/t2mi_ts_null_stuffer.sv
// Buffers whole 188-byte TS packets and replays them at the slot-tick rate,
// filling every empty packet slot with a PID 0x1FFF null packet.
module t2mi_ts_null_stuffer #(
    parameter int unsigned PKT_DEPTH = 4,
    parameter int unsigned LVL_W     = 3
) (
    input logic                   CLK,
    input logic                   RST,
    t2mi_ts_null_stuffer_if.slave bus
);
    localparam int unsigned PKT_LEN   = 188;
    localparam int unsigned MEM_DEPTH = PKT_DEPTH * PKT_LEN;
    localparam int unsigned AW        = $clog2(MEM_DEPTH);
    localparam int unsigned IW        = 8;
    localparam int unsigned LAST_IDX  = PKT_LEN - 1;
    localparam int unsigned LAST_BASE = (PKT_DEPTH - 1) * PKT_LEN;

    typedef enum logic [1:0] {W_HUNT, W_FILL, W_DROP} wr_state_e;
    typedef enum logic [1:0] {R_BOUNDARY, R_PAYLOAD, R_NULLPKT} rd_state_e;

    wr_state_e        wst_q, wst_d;
    logic [IW-1:0]    wr_idx_q, wr_idx_d;
    logic [AW-1:0]    wr_base_q, wr_base_d;
    logic [AW-1:0]    wr_addr_q, wr_addr_d;
    logic             we_c;
    logic [AW-1:0]    we_addr_c;
    logic             commit_c, ovf_c, serr_c, full_c;

    rd_state_e        rst_q, rst_d;
    logic [IW-1:0]    rd_idx_q, rd_idx_d;
    logic [AW-1:0]    rd_base_q, rd_base_d;
    logic [AW-1:0]    rd_addr_q, rd_addr_d;
    logic [AW-1:0]    rd_addr_c;
    logic             pop_c;

    logic             s1_valid_q, s1_valid_d;
    logic             s1_null_q, s1_null_d;
    logic             s1_psync_q, s1_psync_d;
    logic [7:0]       s1_nbyte_q, s1_nbyte_d;

    logic [7:0]       mem [MEM_DEPTH];
    logic [7:0]       ram_q;

    logic [LVL_W-1:0] lvl_q, lvl_d;
    logic [7:0]       ovf_q, ovf_d, serr_q, serr_d;
    logic [7:0]       dout_q, dout_d;
    logic             dval_q, dval_d, psync_q, psync_d;

    // The filling slot is discarded on any new start, so only committed packets decide fullness.
    assign full_c = (lvl_q == LVL_W'(PKT_DEPTH));

    // Write side: hunt for PSYNC, fill one slot, or drop a packet that has no room.
    always_comb begin
        wst_d     = wst_q;
        wr_idx_d  = wr_idx_q;
        wr_base_d = wr_base_q;
        wr_addr_d = wr_addr_q;
        we_c      = 1'b0;
        we_addr_c = wr_addr_q;
        commit_c  = 1'b0;
        ovf_c     = 1'b0;
        serr_c    = 1'b0;
        if (bus.ENA_IN) begin
            if (bus.PSYNC_IN) begin
                serr_c   = (wst_q != W_HUNT) && (wr_idx_q != '0);
                wr_idx_d = IW'(1);
                if (full_c) begin
                    ovf_c = 1'b1;
                    wst_d = W_DROP;
                end else begin
                    we_c      = 1'b1;
                    we_addr_c = wr_base_q;
                    wr_addr_d = wr_base_q + AW'(1);
                    wst_d     = W_FILL;
                end
            end else begin
                case (wst_q)
                    W_FILL: begin
                        we_c      = 1'b1;
                        wr_addr_d = wr_addr_q + AW'(1);
                        if (wr_idx_q == IW'(LAST_IDX)) begin
                            commit_c  = 1'b1;
                            wr_idx_d  = '0;
                            wst_d     = W_HUNT;
                            wr_base_d = (wr_base_q == AW'(LAST_BASE)) ? '0
                                                                      : wr_base_q + AW'(PKT_LEN);
                        end else begin
                            wr_idx_d = wr_idx_q + IW'(1);
                        end
                    end
                    W_DROP: begin
                        if (wr_idx_q == IW'(LAST_IDX)) begin
                            wr_idx_d = '0;
                            wst_d    = W_HUNT;
                        end else begin
                            wr_idx_d = wr_idx_q + IW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Read side: packet-or-null is decided only at a packet boundary.
    always_comb begin
        rst_d      = rst_q;
        rd_idx_d   = rd_idx_q;
        rd_base_d  = rd_base_q;
        rd_addr_d  = rd_addr_q;
        rd_addr_c  = rd_addr_q;
        pop_c      = 1'b0;
        s1_valid_d = bus.SLOT_TICK;
        s1_null_d  = 1'b0;
        s1_psync_d = 1'b0;
        s1_nbyte_d = 8'hFF;
        if (bus.SLOT_TICK) begin
            s1_psync_d = (rd_idx_q == '0);
            case (rd_idx_q)
                IW'(0):  s1_nbyte_d = 8'h47;
                IW'(1):  s1_nbyte_d = 8'h1F;
                IW'(3):  s1_nbyte_d = 8'h10;
                default: s1_nbyte_d = 8'hFF;
            endcase
            case (rst_q)
                R_BOUNDARY: begin
                    rd_idx_d = IW'(1);
                    if (lvl_q != '0) begin
                        rst_d     = R_PAYLOAD;
                        rd_addr_c = rd_base_q;
                        rd_addr_d = rd_base_q + AW'(1);
                    end else begin
                        rst_d     = R_NULLPKT;
                        s1_null_d = 1'b1;
                    end
                end
                R_PAYLOAD: begin
                    rd_addr_d = rd_addr_q + AW'(1);
                    if (rd_idx_q == IW'(LAST_IDX)) begin
                        pop_c     = 1'b1;
                        rd_idx_d  = '0;
                        rst_d     = R_BOUNDARY;
                        rd_base_d = (rd_base_q == AW'(LAST_BASE)) ? '0
                                                                  : rd_base_q + AW'(PKT_LEN);
                    end else begin
                        rd_idx_d = rd_idx_q + IW'(1);
                    end
                end
                R_NULLPKT: begin
                    s1_null_d = 1'b1;
                    if (rd_idx_q == IW'(LAST_IDX)) begin
                        rd_idx_d = '0;
                        rst_d    = R_BOUNDARY;
                    end else begin
                        rd_idx_d = rd_idx_q + IW'(1);
                    end
                end
                default: rst_d = R_BOUNDARY;
            endcase
        end
    end

    // Level, saturating counters and the output stage behind the registered RAM read.
    always_comb begin
        lvl_d = lvl_q;
        case ({commit_c, pop_c})
            2'b10:   lvl_d = lvl_q + LVL_W'(1);
            2'b01:   lvl_d = lvl_q - LVL_W'(1);
            default: lvl_d = lvl_q;
        endcase
        ovf_d   = (ovf_c  && ovf_q  != 8'hFF) ? ovf_q  + 8'd1 : ovf_q;
        serr_d  = (serr_c && serr_q != 8'hFF) ? serr_q + 8'd1 : serr_q;
        dval_d  = s1_valid_q;
        psync_d = s1_valid_q & s1_psync_q;
        dout_d  = 8'h00;
        if (s1_valid_q) begin
            dout_d = s1_null_q ? s1_nbyte_q : ram_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wst_q      <= W_HUNT;
            wr_idx_q   <= '0;
            wr_base_q  <= '0;
            wr_addr_q  <= '0;
            rst_q      <= R_BOUNDARY;
            rd_idx_q   <= '0;
            rd_base_q  <= '0;
            rd_addr_q  <= '0;
            s1_valid_q <= 1'b0;
            s1_null_q  <= 1'b0;
            s1_psync_q <= 1'b0;
            s1_nbyte_q <= 8'h00;
            lvl_q      <= '0;
            ovf_q      <= 8'h00;
            serr_q     <= 8'h00;
            dout_q     <= 8'h00;
            dval_q     <= 1'b0;
            psync_q    <= 1'b0;
        end else begin
            wst_q      <= wst_d;
            wr_idx_q   <= wr_idx_d;
            wr_base_q  <= wr_base_d;
            wr_addr_q  <= wr_addr_d;
            rst_q      <= rst_d;
            rd_idx_q   <= rd_idx_d;
            rd_base_q  <= rd_base_d;
            rd_addr_q  <= rd_addr_d;
            s1_valid_q <= s1_valid_d;
            s1_null_q  <= s1_null_d;
            s1_psync_q <= s1_psync_d;
            s1_nbyte_q <= s1_nbyte_d;
            lvl_q      <= lvl_d;
            ovf_q      <= ovf_d;
            serr_q     <= serr_d;
            dout_q     <= dout_d;
            dval_q     <= dval_d;
            psync_q    <= psync_d;
        end
    end

    // Packet store: one write port, one registered read port.
    always_ff @(posedge CLK) begin
        if (we_c && !RST) begin
            mem[we_addr_c] <= bus.DATA_IN;
        end
        ram_q <= mem[rd_addr_c];
    end

    assign bus.DATA_OUT     = dout_q;
    assign bus.DVALID_OUT   = dval_q;
    assign bus.PSYNC_OUT    = psync_q;
    assign bus.PKT_LEVEL    = lvl_q;
    assign bus.OVF_CNT      = ovf_q;
    assign bus.SYNC_ERR_CNT = serr_q;
endmodule

// File: tb/tb_t2mi_ts_null_stuffer.sv
// Bench for t2mi_ts_null_stuffer: directed scenarios plus random traffic against a queue-based model.
module tb_t2mi_ts_null_stuffer;
    localparam int unsigned PKT_DEPTH = 4;
    localparam int unsigned LVL_W     = 3;
    localparam int unsigned PKT_LEN   = 188;

    typedef logic [7:0] pkt_t [PKT_LEN];
    typedef struct packed {logic [7:0] d; logic ps;} ob_t;
    typedef struct {longint due; logic [7:0] d; logic ps;} exp_t;
    typedef struct {int idx; logic [7:0] d; logic ps;} vec_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    t2mi_ts_null_stuffer_if #(.LVL_W(LVL_W)) bus ();
    t2mi_ts_null_stuffer #(.PKT_DEPTH(PKT_DEPTH), .LVL_W(LVL_W)) dut (.CLK(CLK), .RST(RST), .bus(bus));

    int   tests = 0;
    int   fails = 0;
    int   tick_pct = 100;
    ob_t  got [$];
    ob_t  expv [$];

    // Reference model state: committed bytes, the packet being collected, and the output position.
    logic [7:0] fifo [$];
    logic [7:0] part [$];
    bit         collecting, dropping, rd_pkt;
    int         drop_n, rd_pos, ovf_m, serr_m, m_cnt0;
    logic [7:0] m_d;
    exp_t       expq [$];
    longint     cyc = 0;

    function automatic logic [7:0] null_byte(input int i);
        case (i)
            0:       return 8'h47;
            1:       return 8'h1F;
            3:       return 8'h10;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic int sat(input int v);
        return (v < 255) ? v + 1 : 255;
    endfunction

    function automatic pkt_t make_pkt(input int k);
        pkt_t p;
        p[0] = 8'h47; p[1] = 8'h41; p[2] = 8'hFE; p[3] = 8'(8'h10 + k);
        for (int i = 4; i < PKT_LEN; i++) p[i] = 8'(i - 4 + k * 3);
        return p;
    endfunction

    function automatic pkt_t null_pkt();
        pkt_t p;
        for (int i = 0; i < PKT_LEN; i++) p[i] = null_byte(i);
        return p;
    endfunction

    always @(posedge CLK) begin
        cyc++;
        if (RST === 1'b1) begin
            fifo.delete(); part.delete(); expq.delete();
            collecting = 0; dropping = 0; rd_pkt = 0;
            drop_n = 0; rd_pos = 0; ovf_m = 0; serr_m = 0;
        end else begin
            m_cnt0 = fifo.size() / PKT_LEN;
            if (bus.SLOT_TICK === 1'b1) begin
                if (rd_pos == 0) rd_pkt = (m_cnt0 > 0);
                m_d = rd_pkt ? fifo[rd_pos] : null_byte(rd_pos);
                expq.push_back('{cyc + 1, m_d, rd_pos == 0});
                rd_pos++;
                if (rd_pos == PKT_LEN) begin
                    rd_pos = 0;
                    if (rd_pkt) repeat (PKT_LEN) void'(fifo.pop_front());
                end
            end
            if (bus.ENA_IN === 1'b1) begin
                if (bus.PSYNC_IN === 1'b1) begin
                    if (collecting || dropping) serr_m = sat(serr_m);
                    part.delete(); collecting = 0; dropping = 0;
                    if (m_cnt0 >= PKT_DEPTH) begin
                        ovf_m = sat(ovf_m); dropping = 1; drop_n = 1;
                    end else begin
                        collecting = 1; part.push_back(bus.DATA_IN);
                    end
                end else if (collecting) begin
                    part.push_back(bus.DATA_IN);
                    if (part.size() == PKT_LEN) begin
                        foreach (part[i]) fifo.push_back(part[i]);
                        part.delete(); collecting = 0;
                    end
                end else if (dropping) begin
                    drop_n++;
                    if (drop_n == PKT_LEN) dropping = 0;
                end
            end
        end
    end

    // Per-cycle comparison against the model, and capture of emitted bytes.
    logic       c_v, c_p;
    logic [7:0] c_d;
    always @(negedge CLK) begin
        c_v = 1'b0; c_d = 8'h00; c_p = 1'b0;
        if (expq.size() > 0 && expq[0].due == cyc) begin
            c_v = 1'b1; c_d = expq[0].d; c_p = expq[0].ps;
            void'(expq.pop_front());
        end
        tests++;
        if (bus.DVALID_OUT !== c_v || (c_v && (bus.DATA_OUT !== c_d || bus.PSYNC_OUT !== c_p)) ||
            bus.PKT_LEVEL !== LVL_W'(fifo.size() / PKT_LEN) ||
            bus.OVF_CNT !== 8'(ovf_m) || bus.SYNC_ERR_CNT !== 8'(serr_m)) begin
            fails++;
            $display("FAIL model cyc=%0d dv/data/ps/lvl/ovf/serr got %b/%h/%b/%0d/%0d/%0d expected %b/%h/%b/%0d/%0d/%0d",
                     cyc, bus.DVALID_OUT, bus.DATA_OUT, bus.PSYNC_OUT, bus.PKT_LEVEL, bus.OVF_CNT,
                     bus.SYNC_ERR_CNT, c_v, c_d, c_p, fifo.size() / PKT_LEN, ovf_m, serr_m);
        end
        if (bus.DVALID_OUT === 1'b1) got.push_back('{bus.DATA_OUT, bus.PSYNC_OUT});
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ena, input logic ps, input logic [7:0] d, input int mode);
        @(negedge CLK);
        bus.ENA_IN    = ena;
        bus.PSYNC_IN  = ps;
        bus.DATA_IN   = d;
        bus.SLOT_TICK = (mode == 1) || (mode == 2 && $urandom_range(99, 0) < tick_pct);
    endtask

    task automatic idle(input int n, input int mode);
        repeat (n) drive(1'b0, 1'b0, 8'h00, mode);
    endtask

    task automatic send_bytes(input pkt_t p, input int n, input int mode, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(3, 0) == 0) idle($urandom_range(3, 1), mode);
            drive(1'b1, i == 0, p[i], mode);
        end
    endtask

    task automatic push_pkt(input pkt_t p);
        for (int i = 0; i < PKT_LEN; i++) expv.push_back('{p[i], i == 0});
    endtask

    task automatic cmp_got(input string name);
        int bad = 0;
        check({name, " count"}, 32'(got.size()), 32'(expv.size()));
        for (int i = 0; i < expv.size() && i < got.size(); i++) if (got[i] !== expv[i]) bad++;
        check({name, " bytes"}, 32'(bad), 32'd0);
        expv.delete();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish, expected finish within time limit");
        $fatal(1, "time limit");
    end

    initial begin
        vec_t vt [12];
        pkt_t pa, pb;
        vt[0]  = '{0,   8'h47, 1'b1}; vt[1]  = '{1,   8'h1F, 1'b0}; vt[2]  = '{2,   8'hFF, 1'b0};
        vt[3]  = '{3,   8'h10, 1'b0}; vt[4]  = '{4,   8'hFF, 1'b0}; vt[5]  = '{100, 8'hFF, 1'b0};
        vt[6]  = '{187, 8'hFF, 1'b0}; vt[7]  = '{188, 8'h47, 1'b1}; vt[8]  = '{189, 8'h1F, 1'b0};
        vt[9]  = '{190, 8'hFF, 1'b0}; vt[10] = '{191, 8'h10, 1'b0}; vt[11] = '{375, 8'hFF, 1'b0};

        bus.ENA_IN = 1'b0; bus.PSYNC_IN = 1'b0; bus.DATA_IN = 8'h00; bus.SLOT_TICK = 1'b0;
        idle(3, 0);
        check("reset dvalid", 32'(bus.DVALID_OUT), 32'd0);
        check("reset level", 32'(bus.PKT_LEVEL), 32'd0);
        RST = 1'b0;
        idle(2, 0);

        // Two null packets, with an explicit two-cycle latency probe on the first byte.
        got.delete();
        drive(1'b0, 1'b0, 8'h00, 1);
        drive(1'b0, 1'b0, 8'h00, 0);
        check("latency +1 dvalid", 32'(bus.DVALID_OUT), 32'd0);
        drive(1'b0, 1'b0, 8'h00, 1);
        check("latency +2 byte", {23'd0, bus.DVALID_OUT, bus.DATA_OUT}, {23'd0, 1'b1, 8'h47});
        idle(374, 1);
        idle(3, 0);
        check("null count", 32'(got.size()), 32'd376);
        for (int i = 0; i < 12; i++) begin
            check($sformatf("null[%0d]", vt[i].idx),
                  (vt[i].idx < got.size()) ? 32'(got[vt[i].idx]) : 32'hFFFF_FFFF,
                  32'({vt[i].d, vt[i].ps}));
        end

        // One clean packet through the FIFO.
        pa = make_pkt(0);
        send_bytes(pa, PKT_LEN, 0, 1'b0);
        idle(1, 0);
        check("clean level 1", 32'(bus.PKT_LEVEL), 32'd1);
        got.delete();
        idle(PKT_LEN, 1);
        idle(3, 0);
        push_pkt(pa);
        cmp_got("clean pkt");
        check("clean level 0", 32'(bus.PKT_LEVEL), 32'd0);

        // Packet committed while a null packet is at byte 50.
        got.delete();
        idle(50, 1);
        pb = make_pkt(1);
        send_bytes(pb, PKT_LEN, 0, 1'b0);
        idle(1, 0);
        check("mid-null level", 32'(bus.PKT_LEVEL), 32'd1);
        idle(PKT_LEN - 50 + PKT_LEN, 1);
        idle(3, 0);
        push_pkt(null_pkt());
        push_pkt(pb);
        cmp_got("null then pkt");

        // Five packets into a four-packet FIFO.
        for (int k = 0; k < 5; k++) send_bytes(make_pkt(k + 2), PKT_LEN, 0, 1'b0);
        idle(1, 0);
        check("ovf level", 32'(bus.PKT_LEVEL), 32'd4);
        check("ovf count", 32'(bus.OVF_CNT), 32'd1);
        got.delete();
        idle(5 * PKT_LEN, 1);
        idle(3, 0);
        for (int k = 0; k < 4; k++) push_pkt(make_pkt(k + 2));
        push_pkt(null_pkt());
        cmp_got("ovf output");

        // Early PSYNC at byte 100 aborts the partial packet.
        pa = make_pkt(7);
        pb = make_pkt(9);
        send_bytes(pa, 100, 0, 1'b0);
        send_bytes(pb, PKT_LEN, 0, 1'b0);
        idle(1, 0);
        check("abort serr", 32'(bus.SYNC_ERR_CNT), 32'd1);
        check("abort level", 32'(bus.PKT_LEVEL), 32'd1);
        got.delete();
        idle(PKT_LEN, 1);
        idle(3, 0);
        push_pkt(pb);
        cmp_got("abort output");

        // Reset during payload byte 90 with two packets queued.
        send_bytes(make_pkt(11), PKT_LEN, 0, 1'b0);
        send_bytes(make_pkt(12), PKT_LEN, 0, 1'b0);
        idle(90, 1);
        check("pre-reset level", 32'(bus.PKT_LEVEL), 32'd2);
        RST = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 0);
        check("rst outputs", {21'd0, bus.DVALID_OUT, bus.PSYNC_OUT, bus.DATA_OUT},
              {21'd0, 1'b0, 1'b0, 8'h00});
        check("rst level", 32'(bus.PKT_LEVEL), 32'd0);
        check("rst counters", {16'd0, bus.OVF_CNT, bus.SYNC_ERR_CNT}, 32'd0);
        RST = 1'b0;
        got.delete();
        idle(PKT_LEN, 1);
        idle(3, 0);
        push_pkt(null_pkt());
        cmp_got("post-reset null");

        // Random bursty traffic, stray bytes, aborts and varying tick density.
        for (int k = 0; k < 40; k++) begin
            tick_pct = (k < 15) ? 30 : ((k < 30) ? 100 : 70);
            for (int i = 0; i < PKT_LEN; i++) pa[i] = 8'($urandom);
            pa[0] = 8'h47;
            if ($urandom_range(4, 0) == 0) repeat ($urandom_range(3, 1)) drive(1'b1, 1'b0, 8'($urandom), 2);
            if ($urandom_range(5, 0) == 0) send_bytes(pa, $urandom_range(187, 1), 2, 1'b1);
            send_bytes(pa, PKT_LEN, 2, 1'b1);
        end
        idle(6 * PKT_LEN, 1);
        idle(3, 0);
        check("drain level", 32'(bus.PKT_LEVEL), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
